// File: rtl/fetch_queue.sv
// Instruction fetch front end: block-aligned request generator, in-order tag
// tracking of in-flight requests, and a small queue of returned fetch blocks.
module fetch_queue #(
    parameter int XLEN            = 32,
    parameter int FETCH_WIDTH     = 2,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic [XLEN-1:0]           reset_pc_i,
    input  logic                      redirect_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    output logic                      req_valid_o,
    input  logic                      req_ready_i,
    output logic [XLEN-1:0]           req_addr_o,
    input  logic                      res_valid_i,
    input  logic [FETCH_WIDTH*32-1:0] res_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [FETCH_WIDTH*32-1:0] out_instr_o,
    output logic [XLEN-1:0]           out_pc_o,
    output logic [FETCH_WIDTH-1:0]    out_slot_valid_o
);

    localparam int BW        = FETCH_WIDTH * 32;
    localparam int BLK_BYTES = FETCH_WIDTH * 4;
    localparam int OW        = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW        = $clog2(QUEUE_DEPTH + 1);
    localparam int TPW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int QPW       = $clog2(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] OFF_MASK = XLEN'(BLK_BYTES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [XLEN-1:0]        addr;
        logic [FETCH_WIDTH-1:0] mask;
    } tag_t;

    typedef struct packed {
        logic [BW-1:0]          data;
        logic [XLEN-1:0]        addr;
        logic [FETCH_WIDTH-1:0] mask;
    } entry_t;

    state_t                 state, state_nxt;
    logic [XLEN-1:0]        fetch_pc;
    logic [OW-1:0]          outstanding;
    logic [OW-1:0]          drop_cnt;
    logic [CW-1:0]          occupancy;

    tag_t                   tag_q [MAX_OUTSTANDING];
    logic [TPW-1:0]         tag_wr, tag_rd;
    entry_t                 q_mem [QUEUE_DEPTH];
    logic [QPW-1:0]         q_wr, q_rd;

    logic [XLEN-1:0]        blk_addr, off_word;
    logic [FETCH_WIDTH-1:0] slot_mask;
    logic [CW:0]            reserved;
    logic                   redir, req_fire, keep, pop;
    entry_t                 head;

    function automatic logic [TPW-1:0] tag_next(input logic [TPW-1:0] p);
        return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE && en_i) state_nxt = RUN;
    end

    always_comb begin
        blk_addr = fetch_pc & ~OFF_MASK;
        off_word = (fetch_pc & OFF_MASK) >> 2;
        for (int i = 0; i < FETCH_WIDTH; i++)
            slot_mask[i] = (XLEN'(i) >= off_word);
    end

    // Queue space is reserved for every in-flight request, so responses never overflow.
    assign reserved    = (CW+1)'(outstanding) + (CW+1)'(occupancy);
    assign req_valid_o = (state == RUN) & en_i & ~redirect_i
                       & (outstanding < OW'(MAX_OUTSTANDING))
                       & (reserved < (CW+1)'(QUEUE_DEPTH));
    assign req_addr_o  = blk_addr;

    assign redir    = redirect_i & (state == RUN);
    assign req_fire = req_valid_o & req_ready_i;
    // A response landing in the redirect cycle is stale by definition.
    assign keep     = res_valid_i & (drop_cnt == '0) & ~redir;
    assign pop      = out_valid_o & out_ready_i & ~redir;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc    <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            occupancy   <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(res_valid_i);
            if (state == IDLE) begin
                fetch_pc <= reset_pc_i;
            end else if (redir) begin
                fetch_pc  <= redirect_pc_i;
                drop_cnt  <= outstanding - OW'(res_valid_i);
                occupancy <= '0;
                tag_wr    <= '0;
                tag_rd    <= '0;
                q_wr      <= '0;
                q_rd      <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= blk_addr + XLEN'(BLK_BYTES);
                    tag_wr   <= tag_next(tag_wr);
                end
                if (res_valid_i && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
                if (keep) begin
                    tag_rd <= tag_next(tag_rd);
                    q_wr   <= q_wr + QPW'(1);
                end
                if (pop) q_rd <= q_rd + QPW'(1);
                occupancy <= occupancy + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) tag_q[tag_wr] <= '{addr: blk_addr, mask: slot_mask};
        if (keep)     q_mem[q_wr]   <= '{data: res_data_i, addr: tag_q[tag_rd].addr,
                                         mask: tag_q[tag_rd].mask};
    end

    assign head             = q_mem[q_rd];
    assign out_valid_o      = (occupancy != '0);
    assign out_instr_o      = out_valid_o ? head.data : '0;
    assign out_pc_o         = out_valid_o ? head.addr : '0;
    assign out_slot_valid_o = out_valid_o ? head.mask : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: an in-order memory model plus a
// list-based model of in-flight requests and the delivered block stream.
module tb_fetch_queue;
    localparam int FW = 2;
    localparam int QD = 4;
    localparam int MO = 2;

    logic              clk, rst_ni, en_i, redirect_i, req_ready_i, res_valid_i, out_ready_i;
    logic [31:0]       reset_pc_i, redirect_pc_i, req_addr_o, out_pc_o;
    logic              req_valid_o, out_valid_o;
    logic [FW*32-1:0]  res_data_i, out_instr_o;
    logic [FW-1:0]     out_slot_valid_o;

    fetch_queue #(.XLEN(32), .FETCH_WIDTH(FW), .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .reset_pc_i(reset_pc_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_instr_o(out_instr_o),
        .out_pc_o(out_pc_o), .out_slot_valid_o(out_slot_valid_o));

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [FW-1:0] mask; bit stale; int due; } fl_t;
    typedef struct { logic [31:0] addr; logic [FW-1:0] mask; } blk_t;

    fl_t         inflight[$];
    blk_t        mq[$];
    blk_t        pop_log[$];
    logic [31:0] req_log[$];
    logic [31:0] pc;
    bit          run;
    int          cyc, last_due, lat_lo, lat_hi;
    int          n_chk, n_fail;

    function automatic logic [FW*32-1:0] blk_data(input logic [31:0] a);
        logic [FW*32-1:0] d;
        for (int i = 0; i < FW; i++) d[i*32 +: 32] = (a + 32'(4*i)) ^ 32'h5A5A_1234;
        return d;
    endfunction

    function automatic logic [FW-1:0] mask_of(input logic [31:0] p);
        logic [FW-1:0] m;
        int off;
        off = int'(p % (4*FW)) / 4;
        for (int i = 0; i < FW; i++) m[i] = (i >= off);
        return m;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input bit en, input bit rd, input logic [31:0] rpc,
                        input bit rr, input bit orr);
        bit          res_v, exp_req;
        fl_t         e;
        logic [31:0] blk;
        int          d;
        chk("out_valid", 64'(out_valid_o), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("out_pc", 64'(out_pc_o), 64'(mq[0].addr));
            chk("out_mask", 64'(out_slot_valid_o), 64'(mq[0].mask));
            chk("out_instr", 64'(out_instr_o), 64'(blk_data(mq[0].addr)));
        end
        res_v         = inflight.size() > 0 && inflight[0].due <= cyc;
        res_valid_i   = res_v;
        res_data_i    = res_v ? blk_data(inflight[0].addr) : '0;
        en_i          = en;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        req_ready_i   = rr;
        out_ready_i   = orr;
        #1;
        exp_req = run && en && !rd && inflight.size() < MO && inflight.size() + mq.size() < QD;
        chk("req_valid", 64'(req_valid_o), 64'(exp_req));
        blk = pc & ~32'(4*FW - 1);
        if (exp_req) chk("req_addr", 64'(req_addr_o), 64'(blk));
        if (run) begin
            if (!rd && orr && mq.size() > 0) begin
                pop_log.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (res_v) begin
                e = inflight.pop_front();
                if (!e.stale && !rd) mq.push_back('{addr: e.addr, mask: e.mask});
            end
            if (rd) begin
                mq.delete();
                foreach (inflight[i]) inflight[i].stale = 1;
                pc = rpc;
            end else if (exp_req && rr) begin
                d = cyc + int'($urandom_range(lat_hi, lat_lo));
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                inflight.push_back('{addr: blk, mask: mask_of(pc), stale: 0, due: d});
                req_log.push_back(blk);
                pc = blk + 32'(4*FW);
            end
        end else begin
            pc = reset_pc_i;
            if (en) run = 1;
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int base, pb;
        logic [31:0] rpc;
        n_chk = 0; n_fail = 0; cyc = 0; last_due = 0; run = 0; pc = '0;
        lat_lo = 1; lat_hi = 1;
        rst_ni = 0; en_i = 0; redirect_i = 0; redirect_pc_i = '0; req_ready_i = 0;
        res_valid_i = 0; res_data_i = '0; out_ready_i = 0; reset_pc_i = 32'h1000;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 64'(req_valid_o), 64'(0));
        chk("rst_req_addr", 64'(req_addr_o), 64'(0));
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_out_mask", 64'(out_slot_valid_o), 64'(0));
        chk("rst_out_pc", 64'(out_pc_o), 64'(0));
        chk("rst_out_instr", 64'(out_instr_o), 64'(0));
        rst_ni = 1;

        // start-up with 1-cycle memory, decode always ready
        repeat (8) step(1, 0, '0, 1, 1);
        chk("start_req0", 64'(req_log[0]), 64'h1000);
        chk("start_req1", 64'(req_log[1]), 64'h1008);
        chk("start_req2", 64'(req_log[2]), 64'h1010);
        chk("start_pop_pc", 64'(pop_log[0].addr), 64'h1000);
        chk("start_pop_mask", 64'(pop_log[0].mask), 64'(2'b11));
        chk("start_throughput", 64'(pop_log.size() >= 5), 64'(1));

        // misaligned redirect, response arrives in the redirect cycle
        base = req_log.size(); pb = pop_log.size();
        step(1, 1, 32'h2004, 1, 1);
        repeat (6) step(1, 0, '0, 1, 1);
        chk("mis_req0", 64'(req_log[base]), 64'h2000);
        chk("mis_req1", 64'(req_log[base+1]), 64'h2008);
        chk("mis_pop_pc", 64'(pop_log[pb].addr), 64'h2000);
        chk("mis_pop_mask", 64'(pop_log[pb].mask), 64'(2'b10));
        chk("mis_pop_mask2", 64'(pop_log[pb+1].mask), 64'(2'b11));

        // redirect with two requests in flight
        lat_lo = 3; lat_hi = 3;
        repeat (5) step(1, 0, '0, 1, 1);
        pb = pop_log.size();
        step(1, 1, 32'h3000, 1, 1);
        repeat (10) step(1, 0, '0, 1, 1);
        chk("inflight_pop_pc", 64'(pop_log[pb].addr), 64'h3000);

        // backpressure: exactly QD live blocks accepted, then nothing lost
        lat_lo = 1; lat_hi = 2;
        base = req_log.size(); pb = pop_log.size();
        step(1, 1, 32'h4000, 1, 1);
        repeat (12) step(1, 0, '0, 1, 0);
        chk("bp_accepted", 64'(req_log.size() - base), 64'(QD));
        repeat (10) step(1, 0, '0, 1, 1);
        for (int i = 0; i < 6; i++)
            chk("bp_order", 64'(pop_log[pb+i].addr), 64'(32'h4000 + 32'(8*i)));

        // address wrap
        lat_lo = 1; lat_hi = 1;
        base = req_log.size(); pb = pop_log.size();
        step(1, 1, 32'hFFFF_FFF8, 1, 1);
        repeat (6) step(1, 0, '0, 1, 1);
        chk("wrap_req0", 64'(req_log[base]), 64'hFFFF_FFF8);
        chk("wrap_req1", 64'(req_log[base+1]), 64'h0);
        chk("wrap_pop", 64'(pop_log[pb+1].addr), 64'h0);

        // randomised traffic
        lat_lo = 1; lat_hi = 4;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(1, 0) == 1) rpc = 32'h0000_8000 + ($urandom_range(255, 0) << 2);
            else                           rpc = 32'hFFFF_FFE0 + ($urandom_range(7, 0) << 2);
            step(($urandom_range(7, 0) != 0), ($urandom_range(39, 0) == 0), rpc,
                 ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
